// File: rtl/audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// audio_sample_buffer
//
// Buffers completed I2S samples in a small FIFO and sends them out as a byte
// stream, MSB first, over a valid/ready handshake. This lets the fixed I2S
// sample rate feed a transport that may stall.
//
// Optional feature macro: AUDIO_CHANNEL_TAG_EN
//   Defined   : each sample is preceded by a header byte (0xA0 for left,
//               0xA1 for right). FIFO entries are DATA_SIZE+1 bits wide.
//   Undefined : only data bytes are sent, and i_sample_channel is ignored.
//
// Parameters
//   DATA_SIZE : sample width in bits (8, 16, 24 or 32)
//   DEPTH     : FIFO depth in samples (power of two, >= 2)
//
// Ports
//   i_clk            system clock (same clock as the I2S receiver)
//   i_rst_n          asynchronous active-low reset
//   i_sample_valid   one-cycle pulse, a sample is present
//   i_sample_data    sample value
//   i_sample_channel I2S word select captured with the sample
//   o_byte_data      output byte (registered)
//   o_byte_valid     o_byte_data is valid (registered)
//   i_byte_ready     consumer accepts the byte
//   o_fifo_count     number of samples stored in the FIFO
//   o_overflow       sticky flag: a sample was dropped
//   i_overflow_clr   synchronous clear of o_overflow
// -----------------------------------------------------------------------------
module audio_sample_buffer #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sample_valid,
  input  logic [DATA_SIZE-1:0]   i_sample_data,
  input  logic                   i_sample_channel,
  output logic [7:0]             o_byte_data,
  output logic                   o_byte_valid,
  input  logic                   i_byte_ready,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_overflow,
  input  logic                   i_overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

`ifdef AUDIO_CHANNEL_TAG_EN
  localparam int TAG_B   = 1;
  localparam int ENTRY_W = DATA_SIZE + 1;
`else
  localparam int TAG_B   = 0;
  localparam int ENTRY_W = DATA_SIZE;
`endif

  // Bytes sent per sample; index 0 is the header when tagging is enabled.
  localparam int NBYTES = DATA_SIZE / 8 + TAG_B;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int NSLOT  = 2 ** IW;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [ENTRY_W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic                 r_overflow;

  logic [ENTRY_W-1:0]   r_shift;
  logic [IW-1:0]        r_byte_idx;
  logic [7:0]           r_byte_data;
  logic                 r_byte_valid;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_advance;
  logic                 w_handshake;
  logic                 w_last_byte;
  logic [IW-1:0]        w_idx_inc;
  logic [ENTRY_W-1:0]   w_wr_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic [7:0]           w_head_bytes  [NSLOT];
  logic [7:0]           w_shift_bytes [NSLOT];

`ifdef AUDIO_CHANNEL_TAG_EN
  assign w_wr_entry = {i_sample_channel, i_sample_data};
`else
  logic w_unused_channel;
  assign w_unused_channel = i_sample_channel;
  assign w_wr_entry       = i_sample_data;
`endif

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_head      = r_mem[r_rd_ptr];
  assign w_handshake = r_byte_valid & i_byte_ready;
  assign w_last_byte = (r_byte_idx == IW'(NBYTES - 1));
  assign w_idx_inc   = r_byte_idx + IW'(1);

  // A full FIFO can still accept a sample when the serializer pops in the
  // same cycle: the freed slot is the one being written.
  assign w_push = i_sample_valid & (~w_full | w_pop);
  assign w_drop = i_sample_valid & w_full & ~w_pop;

  // Byte lanes of an entry in transmit order, for both the FIFO head (used
  // on a pop) and the held sample (used when advancing).
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_byte
    if (gi < TAG_B) begin : g_hdr
      assign w_head_bytes[gi]  = {7'h50, w_head[ENTRY_W-1]};
      assign w_shift_bytes[gi] = {7'h50, r_shift[ENTRY_W-1]};
    end else if (gi < NBYTES) begin : g_data
      localparam int LSB = DATA_SIZE - 8 * (gi - TAG_B + 1);
      assign w_head_bytes[gi]  = w_head[LSB +: 8];
      assign w_shift_bytes[gi] = r_shift[LSB +: 8];
    end else begin : g_pad
      assign w_head_bytes[gi]  = 8'h00;
      assign w_shift_bytes[gi] = 8'h00;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage, pointers, occupancy and overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A new drop beats a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_overflow_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_handshake) begin
          if (!w_last_byte) begin
            w_advance = 1'b1;
          end else if (r_count != '0) begin
            // Chain straight into the next sample, no idle cycle.
            w_pop = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_byte_idx   <= '0;
      r_byte_data  <= 8'h00;
      r_byte_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_byte_valid <= (w_state_next == ST_SEND);
      // Without a pop or advance the byte register holds, which keeps the
      // output stable during a stall.
      if (w_pop) begin
        r_shift     <= w_head;
        r_byte_idx  <= '0;
        r_byte_data <= w_head_bytes[0];
      end else if (w_advance) begin
        r_byte_idx  <= w_idx_inc;
        r_byte_data <= w_shift_bytes[w_idx_inc];
      end
    end
  end

  assign o_byte_data  = r_byte_data;
  assign o_byte_valid = r_byte_valid;
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// tb_audio_sample_buffer
//
// Directed bench for audio_sample_buffer with DATA_SIZE=16, DEPTH=4. Inputs
// change 1 time unit after the rising edge and outputs are sampled there.
// Expected byte streams are built from the pushed sample values.
// -----------------------------------------------------------------------------
module tb_audio_sample_buffer;

  localparam int DATA_SIZE = 16;
  localparam int DEPTH     = 4;

`ifdef AUDIO_CHANNEL_TAG_EN
  localparam int TAG_B = 1;
`else
  localparam int TAG_B = 0;
`endif
  localparam int BPS = TAG_B + DATA_SIZE / 8;

  logic                   clk;
  logic                   rst_n;
  logic                   sample_valid;
  logic [DATA_SIZE-1:0]   sample_data;
  logic                   sample_channel;
  logic [7:0]             byte_data;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   overflow_clr;

  int   n_asrt = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic stall_chk = 1'b0;

  logic [7:0] rx_q  [$];
  logic [7:0] exp_q [$];
  int         hs_q  [$];

  audio_sample_buffer #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_sample_valid   (sample_valid),
    .i_sample_data    (sample_data),
    .i_sample_channel (sample_channel),
    .o_byte_data      (byte_data),
    .o_byte_valid     (byte_valid),
    .i_byte_ready     (byte_ready),
    .o_fifo_count     (fifo_count),
    .o_overflow       (overflow),
    .i_overflow_clr   (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: record a handshake seen before the edge, then check stall
  // stability after it.
  task automatic step();
    logic       pend;
    logic [7:0] hold;
    pend = stall_chk && byte_valid && !byte_ready;
    hold = byte_data;
    if (byte_valid && byte_ready) begin
      rx_q.push_back(byte_data);
      hs_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend) begin
      chk("stall_valid", byte_valid, 1);
      chk("stall_data", byte_data, hold);
    end
  endtask

  task automatic add_exp(input logic [15:0] d, input logic ch);
    if (TAG_B != 0) exp_q.push_back({7'h50, ch});
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic drain(input string tag);
    logic done;
    done         = 1'b0;
    byte_ready   = 1'b1;
    sample_valid = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!byte_valid && fifo_count == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk({tag, "_drained"}, done, 1);
  endtask

  task automatic chk_contig(input string tag);
    if (hs_q.size() > 1)
      chk({tag, "_contig"}, hs_q[hs_q.size()-1] - hs_q[0], hs_q.size() - 1);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
    hs_q.delete();
  endtask

  task automatic push(input logic [15:0] d, input logic ch);
    sample_valid   = 1'b1;
    sample_data    = d;
    sample_channel = ch;
    step();
    sample_valid   = 1'b0;
  endtask

  initial begin
    logic done;
    int   pushed;
    logic [15:0] d;

    rst_n          = 1'b0;
    sample_valid   = 1'b0;
    sample_data    = '0;
    sample_channel = 1'b0;
    byte_ready     = 1'b0;
    overflow_clr   = 1'b0;

    // ---- reset state ----
    step(); step(); step();
    chk("rst_valid", byte_valid, 0);
    chk("rst_data", byte_data, 8'h00);
    chk("rst_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    step();

    // ---- single sample 0x1234 ----
    byte_ready = 1'b1;
    add_exp(16'h1234, 1'b0);
    push(16'h1234, 1'b0);
    chk("t1_count1", fifo_count, 1);
    chk("t1_valid_lo", byte_valid, 0);
    step();
    chk("t1_valid_hi", byte_valid, 1);
    chk("t1_first", byte_data, exp_q[0]);
    chk("t1_count0", fifo_count, 0);
    drain("t1");
    chk_contig("t1");
    chk_stream("t1");

    // ---- back-to-back samples ----
    add_exp(16'hAAAA, 1'b0);
    add_exp(16'h5555, 1'b1);
    add_exp(16'h0F0F, 1'b0);
    push(16'hAAAA, 1'b0);
    push(16'h5555, 1'b1);
    push(16'h0F0F, 1'b0);
    drain("t2");
    chk_contig("t2");
    chk_stream("t2");

    // ---- full FIFO and overflow ----
    stall_chk  = 1'b1;
    byte_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 5) add_exp(16'(k), 1'b0);
      push(16'(k), 1'b0);
    end
    chk("t3_count_full", fifo_count, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_valid_held", byte_valid, 1);
    chk("t3_data_held", byte_data, exp_q[0]);
    step(); step();
    drain("t3");
    chk_stream("t3");
    chk("t3_overflow_sticky", overflow, 1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("t3_overflow_clr", overflow, 0);

    // ---- drop with simultaneous clear; push+pop on a full FIFO ----
    byte_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      add_exp(16'h0010 + 16'(k), 1'b0);
      push(16'h0010 + 16'(k), 1'b0);
    end
    overflow_clr = 1'b1;
    push(16'h0016, 1'b0);
    chk("t3b_set_wins", overflow, 1);
    chk("t3b_count", fifo_count, 4);
    step();
    overflow_clr = 1'b0;
    chk("t3b_cleared", overflow, 0);
    byte_ready = 1'b1;
    for (int c = 0; c < 10 && rx_q.size() < BPS - 1; c++) step();
    add_exp(16'h0017, 1'b0);
    push(16'h0017, 1'b0);
    chk("t3b_count_pushpop", fifo_count, 4);
    chk("t3b_no_drop", overflow, 0);
    chk("t3b_next_first", byte_data, exp_q[BPS]);
    drain("t3b");
    chk_stream("t3b");

    // ---- stall stability with random ready ----
    pushed = 0;
    done   = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (pushed == 16 && !byte_valid && fifo_count == 0) begin
        done = 1'b1;
        break;
      end
      byte_ready = 1'($urandom_range(0, 1));
      if (pushed < 16 && fifo_count < 2 && (c % 3) == 0) begin
        d = 16'(16'h0A5C + pushed * 16'h1F31);
        add_exp(d, 1'(pushed));
        sample_valid   = 1'b1;
        sample_data    = d;
        sample_channel = 1'(pushed);
        pushed++;
      end else begin
        sample_valid = 1'b0;
      end
      step();
    end
    sample_valid = 1'b0;
    chk("t4_done", done, 1);
    chk("t4_no_overflow", overflow, 0);
    chk_stream("t4");

    // ---- reset mid-operation ----
    byte_ready = 1'b1;
    add_exp(16'hBEEF, 1'b0);
    push(16'hBEEF, 1'b0);
    for (int c = 0; c < 20 && rx_q.size() < TAG_B + 1; c++) step();
    byte_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push(16'h2200 + 16'(k), 1'b0);
    chk("t5_count_full", fifo_count, 4);
    chk("t5_overflow", overflow, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", byte_valid, 0);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_overflow", overflow, 0);
    chk("t5_rst_data", byte_data, 8'h00);
    while (exp_q.size() > TAG_B + 1) void'(exp_q.pop_back());
    chk_stream("t5_pre");
    step(); step();
    rst_n = 1'b1;
    step();
    add_exp(16'h1111, 1'b0);
    push(16'h1111, 1'b0);
    drain("t5_post");
    chk_stream("t5_post");

    // ---- channel handling ----
    push(16'h1234, 1'b1);
    push(16'h5678, 1'b0);
    drain("t6");
`ifdef AUDIO_CHANNEL_TAG_EN
    exp_q.push_back(8'hA1);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
`else
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h56);
    exp_q.push_back(8'h78);
`endif
    chk_stream("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_buffer.md
# audio_sample_buffer

Downstream stage of the I2S microphone receiver. Captures each completed sample pulse (`audio_data` + `ready`) into a small FIFO and drains it as a byte stream, MSB first, over a valid/ready handshake. The output feeds the SPI/UART transport logic. Decouples the fixed I2S sample rate from a transport that may stall.

## Interface
- `DATA_SIZE`, 16: sample width in bits; must be 8, 16, 24 or 32.
- `DEPTH`, 8: FIFO depth in samples; power of 2, ≥ 2.
- `clk`  in  1  system clock; the same clock as the receiver.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_valid`  in  1  one-cycle pulse; driven by the receiver's `ready`.
- `sample_data`  in  DATA_SIZE  sample; driven by the receiver's `audio_data`.
- `sample_channel`  in  1  receiver's `i2s_ws`, sampled together with `sample_valid`.
- `byte_data`  out  8  output byte.
- `byte_valid`  out  1  `byte_data` is valid.
- `byte_ready`  in  1  consumer accepts the byte.
- `fifo_count`  out  $clog2(DEPTH)+1  number of stored samples.
- `overflow`  out  1  sticky flag: a sample was dropped.
- `overflow_clr`  in  1  synchronous clear of `overflow`.

## Operation
- **Reset values:** all outputs 0; FIFO empty; pointers 0; FSM in IDLE. Reset clears all state asynchronously, including mid-transfer. Any partially sent sample is lost.
- **Write:**
  - On a cycle with `sample_valid=1` and the FIFO not full, push {`sample_channel`, `sample_data`}.
  - If the FIFO is full and no pop occurs that cycle, drop the sample and set `overflow`.
  - If the FIFO is full and a pop occurs in the same cycle, accept the write; the count is unchanged.
- **Overflow flag:** `overflow_clr` and a new drop in the same cycle leave `overflow=1` (set wins).
- **Pointers:** `$clog2(DEPTH)` bits, wrapping naturally. `fifo_count` is derived from a separate counter: +1 on push, −1 on pop, unchanged on push+pop.
- **Serializer FSM:**
  - **IDLE:** if `fifo_count>0` (registered value), pop the head into the shift register, set the byte index to 0, and go to SEND.
  - **SEND:** `byte_valid=1`. A handshake is `byte_valid & byte_ready`.
    - On a handshake that is not the last byte: advance to the next byte.
    - On a handshake on the last byte with `fifo_count>0`: pop the next sample and stay in SEND, with no bubble.
    - On a handshake on the last byte with the FIFO empty: go to IDLE.
- **Byte order:** `DATA_SIZE/8` data bytes, most-significant byte first.
- **Stalls:** `byte_data` and `byte_valid` stay stable while `byte_valid=1` and `byte_ready=0`.
- **Same-cycle push and pop:** a push and a pop in the same cycle on an empty FIFO cannot occur, because a pop requires the registered `fifo_count>0`.

## Timing
- Push at edge T: `fifo_count` updates at T+1.
- Sample pushed into an empty FIFO in IDLE: pop at edge T+1; `byte_valid=1` and the first byte on `byte_data` from T+2.
- Throughput with `byte_ready` held high: one byte per cycle, continuous across samples.
- All outputs are registered; no combinational path from `byte_ready` to `byte_data`.
- Required drain rate: the consumer must average at least `DATA_SIZE/8` (+1 with tags) bytes per sample period, or overflow will eventually occur.

## Configuration
- **`AUDIO_CHANNEL_TAG_EN` defined:**
  - Each sample is preceded by a header byte, 0xA0 for `sample_channel=0` (left) or 0xA1 for `sample_channel=1` (right).
  - Bytes per sample become `DATA_SIZE/8+1`; the header is byte index 0.
  - FIFO entries are `DATA_SIZE+1` bits wide.
- **Undefined:**
  - `sample_channel` is ignored; FIFO entries are `DATA_SIZE` bits wide.
  - Only data bytes are sent.

## Test plan
Parameters: `DATA_SIZE=16`, `DEPTH=4`.

- **Single sample:** reset, then push 0x1234 with `byte_ready=1` → `byte_valid` rises 2 cycles after the push; bytes 0x12, 0x34 on consecutive cycles; `fifo_count` goes 0→1→0.
- **Back-to-back samples:** push 0xAAAA, 0x5555, 0x0F0F on consecutive cycles with `byte_ready=1` → 6 contiguous bytes AA AA 55 55 0F 0F; no gap between samples.
- **Full FIFO and overflow:** hold `byte_ready=0` and push 6 samples (0x0001..0x0006):
  - `fifo_count` saturates at 4; one sample sits in the shift register (byte 0x00 is held).
  - 0x0006 is dropped and `overflow=1`.
  - Release `byte_ready` → output is 00 01 00 02 00 03 00 04 00 05.
  - Then assert `overflow_clr` → `overflow=0`.
- **Stall stability:** toggle `byte_ready` pseudo-randomly while streaming 16 samples → the received stream equals the pushed sequence; `byte_data` never changes while `byte_valid=1` and `byte_ready=0`.
- **Reset mid-operation:** assert `rst_n=0` in the middle of sample 0xBEEF (after 0xBE has been accepted) → `byte_valid`, `fifo_count` and `overflow` go to 0 immediately. After release, push 0x1111 → output 11 11 only.
- **With `AUDIO_CHANNEL_TAG_EN`:** push 0x1234 with `sample_channel=1`, then 0x5678 with `sample_channel=0` → output A1 12 34 A0 56 78.
